// File: rtl/note_scheduler.sv
// Frame scheduler: buffers multi-track packets and plays each one as a frame of
// per-track notes. Define NOTE_SCHED_SUSTAIN_EN to hold notes on after an underrun.
module note_track (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        play,
    input  logic        tick,
    input  logic        park,
    input  logic [15:0] word_per,
    input  logic [7:0]  word_dur,
    output logic [15:0] period,
    output logic        note_en,
    output logic        note_start,
    output logic        expire
);
    logic [7:0] dur_cnt;
    logic [7:0] dur_dec;
    logic       park_en;

    assign dur_dec = (tick && dur_cnt != 8'd0) ? dur_cnt - 8'd1 : dur_cnt;
    // Looking at the post-tick value lets the frame end on the same edge the last note expires.
    assign expire  = (dur_dec == 8'd0);

`ifdef NOTE_SCHED_SUSTAIN_EN
    assign park_en = (period != 16'd0);
`else
    assign park_en = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            period     <= '0;
            dur_cnt    <= '0;
            note_en    <= 1'b0;
            note_start <= 1'b0;
        end else begin
            note_start <= load && (word_dur != 8'd0) && (word_per != 16'd0);
            if (load) begin
                period  <= word_per;
                dur_cnt <= word_dur;
                note_en <= (word_dur != 8'd0) && (word_per != 16'd0);
            end else if (play) begin
                dur_cnt <= dur_dec;
                note_en <= park ? park_en : ((dur_dec != 8'd0) && (period != 16'd0));
            end
        end
    end
endmodule

module note_scheduler #(
    parameter int NUM_TRACKS  = 4,
    parameter int PACKET_SIZE = 24,
    parameter int TICK_DIV    = 10000,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_TRACKS*PACKET_SIZE-1:0] pkt_data,
    input  logic                              pkt_valid,
    output logic                              pkt_ready,
    output logic [NUM_TRACKS*16-1:0]          period_out,
    output logic [NUM_TRACKS-1:0]             note_en,
    output logic [NUM_TRACKS-1:0]             note_start,
    output logic                              busy,
    output logic                              underrun
);
    localparam int PKT_W = NUM_TRACKS*PACKET_SIZE;
    localparam int PW    = $clog2(TICK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t                 state_q, state_d;
    logic [PKT_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [PKT_W-1:0]       head;
    logic [PW-1:0]          presc;
    logic [NUM_TRACKS-1:0]  expire;
    logic                   push, empty, all_exp, tick;
    logic                   load, play, park;

    assign pkt_ready = (count != CW'(FIFO_DEPTH));
    assign push      = pkt_valid && pkt_ready;
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign all_exp   = &expire;
    assign tick      = play && (presc == PW'(TICK_DIV-1));
    assign park      = play && all_exp && empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pkt_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            if (push && !load)      count <= count + CW'(1);
            else if (!push && load) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)     presc <= '0;
        else if (load)  presc <= '0;
        else if (play)  presc <= tick ? '0 : presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)     underrun <= 1'b0;
        else if (park)  underrun <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = LOAD;
            LOAD:    state_d = PLAY;
            PLAY:    if (all_exp) state_d = empty ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        play = 1'b0;
        busy = 1'b0;
        case (state_q)
            LOAD:    begin load = 1'b1; busy = 1'b1; end
            PLAY:    begin play = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // Track 0 lives in the most significant word of both the packet and period_out.
    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
        localparam int LO = (NUM_TRACKS-1-t)*PACKET_SIZE;
        note_track u_trk (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .play       (play),
            .tick       (tick),
            .park       (park),
            .word_per   (head[LO+PACKET_SIZE-1 -: 16]),
            .word_dur   (head[LO +: 8]),
            .period     (period_out[(NUM_TRACKS-1-t)*16 +: 16]),
            .note_en    (note_en[t]),
            .note_start (note_start[t]),
            .expire     (expire[t])
        );
    end
endmodule

// File: tb/tb_note_scheduler.sv
// Directed self-checking bench for note_scheduler (TICK_DIV=4, FIFO_DEPTH=2).
module tb_note_scheduler;
    localparam int NT = 4, PS = 24, TD = 4, FD = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NT*PS-1:0] pkt_data = '0;
    logic            pkt_valid = 1'b0;
    logic            pkt_ready;
    logic [NT*16-1:0] period_out;
    logic [NT-1:0]   note_en, note_start;
    logic            busy, underrun;
    int              checks = 0, errors = 0;

    always #5 clk = ~clk;

    note_scheduler #(.NUM_TRACKS(NT), .PACKET_SIZE(PS), .TICK_DIV(TD), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .period_out (period_out),
        .note_en    (note_en),
        .note_start (note_start),
        .busy       (busy),
        .underrun   (underrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NT*PS-1:0] d);
        pkt_valid = 1'b1;
        pkt_data  = d;
        step(1);
        pkt_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    // Enables expected after a frame ends with nothing queued.
    function automatic logic [3:0] park(input logic [3:0] m);
`ifdef NOTE_SCHED_SUSTAIN_EN
        return m;
`else
        return 4'b0000 & m;
`endif
    endfunction

    function automatic logic [95:0] rep4(input logic [15:0] p, input logic [7:0] d);
        return {4{p, d}};
    endfunction

    initial begin
        // reset state
        step(2);
        chk("rst_en", note_en, 4'b0000);
        chk("rst_start", note_start, 4'b0000);
        chk("rst_period", period_out, 64'h0);
        chk("rst_ready", pkt_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        reset = 1'b1;

        // single long frame, latency and underrun
        push(96'h0114ff_0217ff_0114ff_0217ff);
        chk("t1_idle", busy, 1'b0);
        step(1);
        chk("t1_load_busy", busy, 1'b1);
        chk("t1_load_en", note_en, 4'b0000);
        step(1);
        chk("t1_en", note_en, 4'b1111);
        chk("t1_start", note_start, 4'b1111);
        chk("t1_period", period_out, 64'h0114_0217_0114_0217);
        step(1019);
        chk("t1_en_last", note_en, 4'b1111);
        chk("t1_start_low", note_start, 4'b0000);
        step(1);
        chk("t1_en_end", note_en, park(4'b1111));
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_underrun", underrun, 1'b1);
        push(rep4(16'h0300, 8'h01));
        step(2);
        chk("t1_retrig_start", note_start, 4'b1111);
        chk("t1_retrig_en", note_en, 4'b1111);
        step(4);
        chk("t1_retrig_end", note_en, park(4'b1111));
        chk("t1_retrig_busy", busy, 1'b0);

        // back-to-back frames, durations 2 then 3
        do_reset();
        chk("t2_underrun_clr", underrun, 1'b0);
        pkt_valid = 1'b1;
        pkt_data  = rep4(16'h0010, 8'h02);
        step(1);
        pkt_data  = rep4(16'h0020, 8'h03);
        step(1);
        pkt_valid = 1'b0;
        chk("t2_full", pkt_ready, 1'b0);
        step(1);
        chk("t2_f1_en", note_en, 4'b1111);
        chk("t2_f1_period", period_out, 64'h0010_0010_0010_0010);
        chk("t2_ready", pkt_ready, 1'b1);
        step(7);
        chk("t2_f1_last", note_en, 4'b1111);
        step(1);
        chk("t2_gap_en", note_en, 4'b0000);
        chk("t2_gap_busy", busy, 1'b1);
        chk("t2_gap_underrun", underrun, 1'b0);
        step(1);
        chk("t2_f2_en", note_en, 4'b1111);
        chk("t2_f2_start", note_start, 4'b1111);
        chk("t2_f2_period", period_out, 64'h0020_0020_0020_0020);
        step(11);
        chk("t2_f2_last", note_en, 4'b1111);
        step(1);
        chk("t2_f2_end", note_en, park(4'b1111));
        chk("t2_underrun", underrun, 1'b1);

        // mixed durations, rest on track 3
        do_reset();
        push({16'h0100, 8'h01, 16'h0200, 8'h04, 16'h0300, 8'h00, 16'h0000, 8'h02});
        step(2);
        chk("t3_en", note_en, 4'b0011);
        chk("t3_start", note_start, 4'b0011);
        chk("t3_period", period_out, 64'h0100_0200_0300_0000);
        step(3);
        chk("t3_en_4", note_en, 4'b0011);
        step(1);
        chk("t3_t0_drop", note_en, 4'b0010);
        step(11);
        chk("t3_en_16", note_en, 4'b0010);
        step(1);
        chk("t3_end_en", note_en, park(4'b0111));
        chk("t3_end_busy", busy, 1'b0);
        chk("t3_underrun", underrun, 1'b1);

        // pkt_valid held high until the FIFO fills
        do_reset();
        pkt_valid = 1'b1;
        pkt_data  = rep4(16'h0A01, 8'h01);
        step(1);
        chk("t4_ready_1", pkt_ready, 1'b1);
        pkt_data  = rep4(16'h0A02, 8'h01);
        step(1);
        chk("t4_ready_full", pkt_ready, 1'b0);
        pkt_data  = rep4(16'h0A03, 8'h01);
        step(1);
        chk("t4_ready_pop", pkt_ready, 1'b1);
        chk("t4_p1", period_out, 64'h0A01_0A01_0A01_0A01);
        step(1);
        chk("t4_ready_refull", pkt_ready, 1'b0);
        pkt_valid = 1'b0;
        step(3);
        chk("t4_load_en", note_en, 4'b0000);
        chk("t4_load_busy", busy, 1'b1);
        step(1);
        chk("t4_p2", period_out, 64'h0A02_0A02_0A02_0A02);
        chk("t4_p2_en", note_en, 4'b1111);
        step(5);
        chk("t4_p3", period_out, 64'h0A03_0A03_0A03_0A03);
        step(4);
        chk("t4_end_busy", busy, 1'b0);
        chk("t4_end_en", note_en, park(4'b1111));

        // push and pop on the same edge
        do_reset();
        push(rep4(16'h0B05, 8'h01));
        step(2);
        pkt_valid = 1'b1;
        pkt_data  = rep4(16'h0B06, 8'h01);
        step(1);
        pkt_valid = 1'b0;
        chk("t5_ready_q1", pkt_ready, 1'b1);
        step(3);
        chk("t5_load_busy", busy, 1'b1);
        pkt_valid = 1'b1;
        pkt_data  = rep4(16'h0B07, 8'h01);
        step(1);
        pkt_valid = 1'b0;
        chk("t5_ready_pushpop", pkt_ready, 1'b1);
        chk("t5_p6", period_out, 64'h0B06_0B06_0B06_0B06);
        step(4);
        chk("t5_gap_en", note_en, 4'b0000);
        step(1);
        chk("t5_p7", period_out, 64'h0B07_0B07_0B07_0B07);
        chk("t5_p7_start", note_start, 4'b1111);
        step(4);
        chk("t5_end_busy", busy, 1'b0);
        chk("t5_underrun", underrun, 1'b1);

        // reset mid-frame with a packet queued
        push(rep4(16'h0555, 8'hff));
        push(rep4(16'h0666, 8'hff));
        step(10);
        chk("t6_playing", note_en, 4'b1111);
        reset = 1'b0;
        step(1);
        chk("t6_en", note_en, 4'b0000);
        chk("t6_period", period_out, 64'h0);
        chk("t6_ready", pkt_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_underrun", underrun, 1'b0);
        reset = 1'b1;
        step(5);
        chk("t6_discard_busy", busy, 1'b0);
        chk("t6_discard_en", note_en, 4'b0000);

        // all-zero durations: LOAD plus one PLAY cycle
        push(rep4(16'h0777, 8'h00));
        step(1);
        chk("t7_load", busy, 1'b1);
        step(1);
        chk("t7_play_busy", busy, 1'b1);
        chk("t7_play_en", note_en, 4'b0000);
        chk("t7_play_start", note_start, 4'b0000);
        chk("t7_period", period_out, 64'h0777_0777_0777_0777);
        step(1);
        chk("t7_idle", busy, 1'b0);
        chk("t7_underrun", underrun, 1'b1);
        chk("t7_en", note_en, park(4'b1111));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
